// File: rtl/aperture_scheduler_pkg.sv
// Shared constants and FSM encoding for the aperture scheduler slice.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package aperture_scheduler_pkg;

  // Configuration page of the A8 map. The aperture decoders keep it out of
  // apInRange, so the scheduler never has to look at it.
  localparam logic [7:0] CFG_PAGE   = 8'hD1;
  localparam int         AP_IDX_W   = 4;
  localparam logic [7:0] RD_DEFAULT = 8'hFF;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WDATA = 2'd1,
    REQ   = 2'd2,
    HOLD  = 2'd3
  } state_t;

endpackage

// File: rtl/aperture_scheduler_ap_prio_enc.sv
// Lowest-index-wins priority encoder over N request lines.
// Latency: combinational.
// Backpressure: none.
// Ports: req (N request bits) -> hit (any set), idx (lowest set index, 0 if none).
module ap_prio_enc #(
  parameter int N     = 16,
  parameter int IDX_W = 4
) (
  input  logic [N-1:0]     req,
  output logic             hit,
  output logic [IDX_W-1:0] idx
);

  always_comb begin
    hit = |req;
    idx = '0;
    // Scan downwards so the last assignment is the lowest set index.
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) idx = IDX_W'(i);
    end
  end

endmodule

// File: rtl/aperture_scheduler.sv
// Resolves an A8 access to one aperture, issues one SDRAM req/ack transaction, returns read data.
// Latency: memReq 1 clk after aValid rises (read) or after wValid (write); data with memAck.
// Backpressure: waits on memAck up to TIMEOUT clks, then aborts with 0xFF and errSticky.
// Ports: A8 bus (a8_*, aValid, wValid, rdData, rdValid), aperture decoders (apInRange,
//        apBaseAddr, apLo), SDRAM port (memReq/memWr/memAddr/memWData, memAck/memRData),
//        status (hitIdx, busy, errSticky).
module aperture_scheduler
  import aperture_scheduler_pkg::*;
#(
  parameter int N_AP    = 16,
  parameter int TIMEOUT = 48,
  parameter int TO_W    = 6
) (
  input  logic                  clk,
  input  logic                  a8_rst_n,
  input  logic                  a8_rw_n,
  input  logic [15:0]           a8_addr,
  input  logic [7:0]            a8_data,
  input  logic                  aValid,
  input  logic                  wValid,
  input  logic [N_AP-1:0]       apInRange,
  input  logic [32*N_AP-1:0]    apBaseAddr,
  input  logic [8*N_AP-1:0]     apLo,
  output logic                  memReq,
  output logic                  memWr,
  output logic [31:0]           memAddr,
  output logic [7:0]            memWData,
  input  logic                  memAck,
  input  logic [7:0]            memRData,
  output logic [7:0]            rdData,
  output logic                  rdValid,
  output logic [AP_IDX_W-1:0]   hitIdx,
  output logic                  busy,
  output logic                  errSticky
);

  state_t              state;
  logic [TO_W-1:0]     to_cnt;
  logic                av_q;
  logic                av_rise;
  logic                hit;
  logic [AP_IDX_W-1:0] win;
  logic [31:0]         win_base;
  logic [7:0]          win_lo;
  logic [7:0]          off;
  logic [31:0]         addr;

  ap_prio_enc #(
    .N     (N_AP),
    .IDX_W (AP_IDX_W)
  ) u_prio (
    .req (apInRange),
    .hit (hit),
    .idx (win)
  );

  always_comb begin
    win_base = '0;
    win_lo   = '0;
    for (int i = 0; i < N_AP; i++) begin
      if (win == AP_IDX_W'(i)) begin
        win_base = apBaseAddr[32*i +: 32];
        win_lo   = apLo[8*i +: 8];
      end
    end
  end

  // Page offset inside the aperture wraps at 8 bits; the final add wraps at 32.
  assign off     = a8_addr[15:8] - win_lo;
  assign addr    = win_base + {16'b0, off, a8_addr[7:0]};
  assign av_rise = aValid && !av_q;
  assign busy    = (state != IDLE);

  always_ff @(posedge clk) begin
    if (!a8_rst_n) begin
      state     <= IDLE;
      to_cnt    <= '0;
      av_q      <= 1'b0;
      memReq    <= 1'b0;
      memWr     <= 1'b0;
      memAddr   <= '0;
      memWData  <= '0;
      rdData    <= RD_DEFAULT;
      rdValid   <= 1'b0;
      hitIdx    <= '0;
      errSticky <= 1'b0;
    end else begin
      // Tracked in every state so an aValid level held across a busy period
      // does not look like a fresh edge once we return to IDLE.
      av_q <= aValid;
      case (state)
        IDLE: begin
          if (av_rise && hit) begin
            memAddr <= addr;
            hitIdx  <= win;
            if (a8_rw_n) begin
              memWr  <= 1'b0;
              memReq <= 1'b1;
              to_cnt <= '0;
              state  <= REQ;
            end else begin
              state  <= WDATA;
            end
          end
        end
        WDATA: begin
          if (wValid) begin
            memWData <= a8_data;
            memWr    <= 1'b1;
            memReq   <= 1'b1;
            to_cnt   <= '0;
            state    <= REQ;
          end else if (!aValid) begin
            state <= IDLE;
          end
        end
        REQ: begin
          // memAck is tested first so it beats a coincident timeout.
          if (memAck) begin
            memReq <= 1'b0;
            if (!memWr) begin
              rdData  <= memRData;
              rdValid <= 1'b1;
              if (!aValid) errSticky <= 1'b1;
            end
            state <= HOLD;
          end else if (to_cnt == TO_W'(TIMEOUT - 1)) begin
            memReq    <= 1'b0;
            errSticky <= 1'b1;
            if (!memWr) begin
              rdData  <= RD_DEFAULT;
              rdValid <= 1'b1;
            end
            state <= HOLD;
          end else begin
            to_cnt <= to_cnt + 1'b1;
          end
        end
        HOLD: begin
          // Evaluated from the cycle after entry, so an overrun read still
          // shows rdValid for exactly one cycle.
          if (!aValid) begin
            rdValid <= 1'b0;
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
